btn_conditioner: RTL
====================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 The block SHALL provide parameter DEBOUNCE_CYCLES, default 10_000, defined as the number of consecutive stable synchronized samples required to accept an edge (10 ms at 1 MHz).
REQ-002 The block SHALL provide parameter LONG_PRESS_CYCLES, default 2_000_000, defined as the hold time in cycles, counted from press_pulse, that qualifies a long press (2 s at 1 MHz).
REQ-003 clk  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 btn_raw  input  1  asynchronous, bouncy push-button level; 1 means pressed.
REQ-006 btn_level  output  1  debounced button level.
REQ-007 press_pulse  output  1  one-cycle strobe marking an accepted press.
REQ-008 release_pulse  output  1  one-cycle strobe marking an accepted release.
REQ-009 long_pulse  output  1  one-cycle strobe marking a long press.
REQ-010 run_en  output  1  registered enable that drives the traffic-light controller's btn input.

Function
REQ-011 btn_raw SHALL pass through a 2-flop synchronizer; only the second flop's output (sync) SHALL feed the remaining logic.
REQ-012 The debounce FSM SHALL have exactly four states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 In IDLE with sync=1, the FSM SHALL go to PRESS_WAIT and load deb_cnt=0.
REQ-014 In PRESS_WAIT, sync=0 SHALL return the FSM to IDLE; otherwise deb_cnt SHALL increment.
- When deb_cnt reaches DEBOUNCE_CYCLES-1, the FSM SHALL go to PRESSED.
- On that same transition, press_pulse SHALL be 1 for that one cycle.
REQ-015 In PRESSED with sync=0, the FSM SHALL go to RELEASE_WAIT and load deb_cnt=0.
REQ-016 In RELEASE_WAIT, sync=1 SHALL return the FSM to PRESSED with no pulse.
- Otherwise deb_cnt SHALL increment.
- At DEBOUNCE_CYCLES-1, the FSM SHALL go to IDLE with release_pulse=1 for one cycle.
REQ-017 btn_level SHALL be 1 exactly while the FSM is in PRESSED or RELEASE_WAIT, registered.
REQ-018 Latency: for a clean rising edge of btn_raw first sampled at edge k, press_pulse SHALL be high in the cycle after edge k+DEBOUNCE_CYCLES+2.
- The release path SHALL have the same latency.
REQ-019 A bounce shorter than DEBOUNCE_CYCLES samples SHALL produce no pulse and no change to btn_level.
REQ-020 hold_cnt SHALL clear on press_pulse and SHALL increment on every cycle in which btn_level=1.
- hold_cnt SHALL saturate at LONG_PRESS_CYCLES.
REQ-021 When hold_cnt first equals LONG_PRESS_CYCLES, long_pulse SHALL be 1 for one cycle.
- long_pulse SHALL fire at most once per press.
- hold_cnt SHALL NOT reset during a RELEASE_WAIT bounce that returns to PRESSED.
REQ-022 run_en SHALL toggle on each press_pulse.
REQ-023 long_pulse SHALL force run_en=0 whatever its prior value (the long press acts as a forced stop).
REQ-024 If press_pulse and long_pulse could coincide, long_pulse SHALL take priority; this is unreachable for LONG_PRESS_CYCLES ≥ 1.
REQ-025 deb_cnt and hold_cnt SHALL each be 26 bits wide.
REQ-026 Both parameters SHALL be in the range 2..2^26-1; counters SHALL never wrap.
REQ-027 At most one of press_pulse and release_pulse SHALL be high in any cycle.

Reset
REQ-028 When rst=1 at a clock edge, the following SHALL hold on the next cycle:
- FSM in IDLE;
- deb_cnt=0 and hold_cnt=0;
- both synchronizer flops = 0;
- btn_level=0, press_pulse=0, release_pulse=0, long_pulse=0, run_en=0.
REQ-029 rst SHALL have priority over all other inputs.
- A reset asserted mid-press SHALL abort the press with no pulses.
- After reset, a held button SHALL be re-qualified from IDLE as a new press.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20)
REQ-030 rst for 2 cycles with btn_raw=1 -> all outputs 0 during reset; press_pulse high exactly 6 cycles after rst falls; run_en=1 on the following cycle.
REQ-031 btn_raw toggles 1,0,1,0 on successive cycles, then is held 0 -> no pulse ever; btn_level and run_en stay 0.
REQ-032 Clean press held 10 cycles, then released -> one press_pulse, run_en=1, btn_level=1; release_pulse 6 cycles after the falling edge; run_en stays 1.
- A second identical press -> run_en=0.
REQ-033 Press held 30 cycles -> long_pulse exactly 20 cycles after press_pulse; run_en=1 then 0; no second long_pulse.
REQ-034 While held, a 2-cycle low glitch on btn_raw -> no release_pulse; btn_level stays 1; hold_cnt continues; long_pulse still occurs on schedule.
REQ-035 rst asserted 2 cycles into PRESS_WAIT -> no press_pulse; with btn_raw still high after reset, press_pulse arrives 6 cycles after rst is deasserted.

Source files
------------

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, four-state debounce FSM,
// long-press detection and a run enable toggled by presses.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 10_000,
  parameter int LONG_PRESS_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic run_en
);

  localparam logic [25:0] DEB_LAST = 26'(DEBOUNCE_CYCLES - 1);
  localparam logic [25:0] LONG_CNT = 26'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  state_t      state, state_nx;
  logic [25:0] deb_cnt, deb_nx;
  logic [25:0] hold_cnt, hold_nx;
  logic        meta, sync;
  logic        press_evt, rel_evt, long_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= btn_raw;
      sync <= meta;
    end
  end

  always_comb begin
    state_nx  = state;
    deb_nx    = deb_cnt;
    press_evt = 1'b0;
    rel_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (sync) begin
          state_nx = PRESS_WAIT;
          deb_nx   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_nx = IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_nx  = PRESSED;
          press_evt = 1'b1;
        end else begin
          deb_nx = deb_cnt + 26'd1;
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_nx = RELEASE_WAIT;
          deb_nx   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_nx = PRESSED;
        end else if (deb_cnt == DEB_LAST) begin
          state_nx = IDLE;
          rel_evt  = 1'b1;
        end else begin
          deb_nx = deb_cnt + 26'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // hold_cnt keeps counting through a release bounce; saturation makes long fire once
  always_comb begin
    hold_nx = hold_cnt;
    if (press_evt)
      hold_nx = '0;
    else if (btn_level && hold_cnt != LONG_CNT)
      hold_nx = hold_cnt + 26'd1;
    long_evt = (hold_nx == LONG_CNT) && (hold_cnt != LONG_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      run_en        <= 1'b0;
    end else begin
      state         <= state_nx;
      deb_cnt       <= deb_nx;
      hold_cnt      <= hold_nx;
      btn_level     <= (state_nx == PRESSED) || (state_nx == RELEASE_WAIT);
      press_pulse   <= press_evt;
      release_pulse <= rel_evt;
      long_pulse    <= long_evt;
      // long press is a forced stop and wins over a toggle
      if (long_pulse)
        run_en <= 1'b0;
      else if (press_pulse)
        run_en <= ~run_en;
    end
  end

endmodule
